// File: rtl/cmip_sync_fifo_reader_pkg.sv
// Shared constants and helpers for the sync-FIFO reader slice.
package cmip_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    // Pointer width with one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_wdth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cmip_sync_fifo_reader_if.sv
// FIFO read port plus output stream handshake of the sync-FIFO reader.
interface cmip_sync_fifo_reader_if #(
    parameter int DATA_WDTH = 32
);
    logic                 o_fifo_rd;
    logic [DATA_WDTH-1:0] i_fifo_dout;
    logic                 i_fifo_empty;
    logic                 o_vld;
    logic [DATA_WDTH-1:0] o_data;
    logic                 o_last;
    logic                 i_rdy;

    modport master (
        output o_fifo_rd, o_vld, o_data, o_last,
        input  i_fifo_dout, i_fifo_empty, i_rdy
    );

    modport slave (
        input  o_fifo_rd, o_vld, o_data, o_last,
        output i_fifo_dout, i_fifo_empty, i_rdy
    );
endinterface

// File: rtl/cmip_sync_fifo_reader_land_buf.sv
// Circular landing buffer: absorbs FIFO read returns and presents the head word.
module cmip_land_buf
    import cmip_pkg::*;
#(
    parameter int DATA_WDTH = 32,
    parameter int BUF_DPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_WDTH-1:0]      push_data,
    input  logic                      pop,
    output logic                      vld,
    output logic [DATA_WDTH-1:0]      data,
    output logic [$clog2(BUF_DPTH):0] cnt
);

    localparam int AW    = $clog2(BUF_DPTH);
    localparam int PTR_W = ptr_wdth(BUF_DPTH);

    logic [DATA_WDTH-1:0] mem [BUF_DPTH];
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

    // Wrap-bit pointers make the difference the exact occupancy, 0..BUF_DPTH.
    assign cnt  = wptr - rptr;
    assign vld  = (cnt != '0);
    assign data = vld ? mem[rptr[AW-1:0]] : '0;

endmodule

// File: rtl/cmip_sync_fifo_reader.sv
// Non-FWFT sync FIFO consumer: credit-limited rd issue, latency absorption and
// re-emission as a framed valid/ready stream.
module cmip_sync_fifo_reader
    import cmip_pkg::*;
#(
    parameter int DATA_WDTH = 32,
    parameter int RD_LAT    = 1,
    parameter int BUF_DPTH  = 4,
    parameter int LEN_WDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    cmip_sync_fifo_reader_if.master bus,
    input  logic                    i_en,
    input  logic [LEN_WDTH-1:0]     i_frm_len,
    output logic                    o_busy,
    output logic [31:0]             o_frm_cnt,
    output logic                    o_unfl_int
);

    localparam int CNT_W = ptr_wdth(BUF_DPTH);
    localparam int SUM_W = CNT_W + 1;

    if (!rd_lat_legal(RD_LAT) || (BUF_DPTH < RD_LAT + 2) ||
        ((BUF_DPTH & (BUF_DPTH - 1)) != 0)) begin : g_bad_cfg
        $error("cmip_sync_fifo_reader: illegal RD_LAT/BUF_DPTH combination");
    end

    logic [RD_LAT-1:0]    rd_p;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W-1:0]     buf_cnt;
    logic                 rd;
    logic                 land;
    logic                 pop;
    logic                 last;
    logic                 buf_vld;
    logic [DATA_WDTH-1:0] buf_data;
    logic [LEN_WDTH-1:0]  wcnt;
    logic [LEN_WDTH-1:0]  len_lat;
    logic [LEN_WDTH-1:0]  len_in;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            inflight = inflight + CNT_W'(rd_p[k]);
        end
    end

    // Every issued read owns a buffer slot from issue until it is popped.
    assign rd = i_rst_n & i_en & ~bus.i_fifo_empty &
                ((SUM_W'(inflight) + SUM_W'(buf_cnt)) < SUM_W'(BUF_DPTH));

    assign land   = rd_p[RD_LAT-1];
    assign pop    = buf_vld & bus.i_rdy;
    assign len_in = (i_frm_len == '0) ? LEN_WDTH'(1) : i_frm_len;
    assign last   = buf_vld & (wcnt == len_lat - LEN_WDTH'(1));

    // Issue -> return: rd_p[k] is the strobe k+1 cycles after issue; the tail
    // marks the cycle in which i_fifo_dout carries that read's word.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_p <= '0;
        end else begin
            rd_p[0] <= rd;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_p[k] <= rd_p[k-1];
            end
        end
    end

    cmip_land_buf #(
        .DATA_WDTH (DATA_WDTH),
        .BUF_DPTH  (BUF_DPTH)
    ) u_land_buf (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (land),
        .push_data (bus.i_fifo_dout),
        .pop       (pop),
        .vld       (buf_vld),
        .data      (buf_data),
        .cnt       (buf_cnt)
    );

    // Length is re-latched between frames: while idle at a frame start, and at
    // the closing pop so back-to-back frames pick up a new length at once.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wcnt      <= '0;
            len_lat   <= LEN_WDTH'(1);
            o_frm_cnt <= '0;
        end else if (pop) begin
            if (last) begin
                wcnt      <= '0;
                len_lat   <= len_in;
                o_frm_cnt <= o_frm_cnt + 32'd1;
            end else begin
                wcnt <= wcnt + LEN_WDTH'(1);
            end
        end else if (wcnt == '0) begin
            len_lat <= len_in;
        end
    end

    assign bus.o_fifo_rd = rd;
    assign bus.o_vld     = buf_vld;
    assign bus.o_data    = buf_data;
    assign bus.o_last    = last;
    assign o_busy        = (inflight != '0) | (buf_cnt != '0);
    assign o_unfl_int    = rd & bus.i_fifo_empty;

endmodule

// File: doc/cmip_sync_fifo_reader.md
# cmip_sync_fifo_reader

Consumer-side controller for the team's sync FIFO in standard (non-FWFT) read mode. It issues `rd` strobes and absorbs the fixed read latency into a small credit-tracked landing buffer. It re-emits the data as a valid/ready stream with frame `last` marking every `i_frm_len` words. It sits between a `cmip_sync_fifo` instance and downstream packetisers or DMA writers, so they never see FIFO latency or empty/underflow hazards.

## Interface
- `DATA_WDTH`, 32: data width.
- `RD_LAT`, 1: FIFO read latency in cycles, legal values 1..2.
- `BUF_DPTH`, 4: landing buffer depth; must be ≥ `RD_LAT`+2 and a power of two.
- `LEN_WDTH`, 16: frame length width.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  synchronous reset, active low.
- `o_fifo_rd`  out  1  FIFO read strobe.
- `i_fifo_dout`  in  DATA_WDTH  FIFO read data, valid `RD_LAT` cycles after `o_fifo_rd`.
- `i_fifo_empty`  in  1  FIFO empty.
- `i_en`  in  1  enable draining.
- `i_frm_len`  in  LEN_WDTH  words per frame; 0 is treated as 1.
- `o_vld`  out  1  stream valid.
- `o_data`  out  DATA_WDTH  stream data.
- `o_last`  out  1  last word of frame.
- `i_rdy`  in  1  stream ready.
- `o_busy`  out  1  reads in flight or buffer non-empty.
- `o_frm_cnt`  out  32  completed frames, wraps.
- `o_unfl_int`  out  1  one-cycle pulse: read issued while FIFO empty (internal error, must never fire).

## Operation
- Reset (`i_rst_n`=0 at a clock edge) clears all state. While in or out of reset, `o_fifo_rd`, `o_vld`, `o_last`, `o_busy`, `o_unfl_int` are 0; `o_data` is 0; `o_frm_cnt` is 0.
- Credit: `inflight` (0..RD_LAT) counts reads issued but not yet returned. `buf_cnt` (0..BUF_DPTH) counts landed words.
- Issue rule: `o_fifo_rd` = `i_en` & ~`i_fifo_empty` & (`inflight` + `buf_cnt` < `BUF_DPTH`). The rule is combinational on registered counters, so one read per cycle is sustainable.
- Return: a shift register of depth `RD_LAT` carries the rd strobe. When its tail is set, `i_fifo_dout` is written into the buffer at `wptr`. The credit rule guarantees no overflow.
- Buffer: circular, `wptr`/`rptr` of width log2(BUF_DPTH)+1 with wrap bit. `o_vld` = buffer non-empty; `o_data` = `mem[rptr]`. A pop occurs on `o_vld` & `i_rdy`.
- Simultaneous land and pop: `buf_cnt` is unchanged and both pointers advance.
- Frame counter `wcnt` (LEN_WDTH bits) counts popped words. `o_last` = `o_vld` & (`wcnt` == `len_lat`−1).
  - On a pop with `o_last`: `wcnt`←0 and `o_frm_cnt` increments; otherwise `wcnt` increments.
- `len_lat` = max(`i_frm_len`,1). It is sampled when `wcnt`==0 and no pop is occurring, and held constant within a frame. A mid-frame `i_frm_len` change applies from the next frame.
- `i_en` deassert: new reads stop immediately. In-flight reads still land and the buffer still drains. `i_en` does not reset `wcnt`.
- `o_busy` = (`inflight`≠0) | (`buf_cnt`≠0).
- `o_unfl_int` pulses if `o_fifo_rd` & `i_fifo_empty`. This is a design assertion.

## Timing
- `o_fifo_rd` at cycle t: data lands at the end of cycle t+RD_LAT, and `o_vld` is seen at t+RD_LAT+1. Minimum FIFO-to-stream latency is therefore `RD_LAT`+1 cycles.
- Throughput is 1 word/cycle with `i_rdy` held high when `BUF_DPTH` ≥ `RD_LAT`+2.
- Stream rules: `o_data` and `o_last` are stable while `o_vld` & ~`i_rdy`. `o_vld` never drops without a pop.
- Outputs `o_vld`, `o_data`, `o_last` derive from registered state only; there is no combinational path from `i_rdy`. `o_fifo_rd` depends combinationally on `i_en` and `i_fifo_empty` only.

## Structure
- Shared package `cmip_pkg`:
  - the `RD_LAT` legal range check constant;
  - the `clog2`-based pointer width helper.
- One sub-module: `cmip_land_buf`, the circular landing buffer with push/pop/count, instantiated once.
- Top level holds the issue/credit logic, latency shift register and frame counter.

## Test plan
- Preload 8 words 0..7, `i_frm_len`=4, `i_rdy`=1, `RD_LAT`=1, `i_en` high:
  - reads on 8 consecutive cycles;
  - stream 0..7 beginning 2 cycles after the first rd, with `o_last` on words 3 and 7;
  - `o_frm_cnt`=2.
- Same data with `i_rdy` toggled randomly:
  - the buffer never exceeds 4 words (`o_fifo_rd` stalls at `inflight`+`buf_cnt`=4);
  - there is no data loss or reordering, and `o_data` is held during stalls.
- FIFO empty after word 2, refilled 5 cycles later:
  - `o_fifo_rd` is 0 while empty and `o_unfl_int` never fires;
  - the frame continues, with `o_last` on the 4th word overall.
- `i_en` deasserted with 1 read in flight and 2 words buffered:
  - 3 words are output, then `o_busy`=0;
  - no further rd is issued.
- `i_frm_len`=0: every word has `o_last`=1. Changing `i_frm_len` from 3 to 2 mid-frame keeps the current frame at 3 words, and the next frame is 2 words.
- Reset asserted mid-stream with `o_vld`=1: the next cycle `o_vld`=0, `o_busy`=0, `o_frm_cnt`=0, and late FIFO data is ignored.
